// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side bus responder: data RAM, LED register, switch port, sticky error
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   mem_cmd   bus command: 00 NONE, 01 READ, 10 WRITE, 11 reserved
//   mem_addr  word address
//   wdata     write data, sampled with WRITE
//   rdata     registered read data, holds when no response
//   rd_valid  one-cycle strobe marking a read response
//   sw        asynchronous switch inputs
//   ledr      LED register
//   err       sticky illegal-access flag
//
// Optional feature: define ACCESS_COUNT_EN to build the RAM read/write access counters
// at CNT_ADDR / CNT_ADDR+1.

module mem_responder #(
    parameter int          DEPTH    = 256,
    parameter int          DW       = 16,
    parameter int          AW       = 9,
    parameter logic [AW-1:0] LED_ADDR = 9'h100,
    parameter logic [AW-1:0] SW_ADDR  = 9'h140,
    parameter logic [AW-1:0] CNT_ADDR = 9'h180
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mem_cmd,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    input  logic [7:0]    sw,
    output logic [7:0]    ledr,
    output logic          err
);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);

    logic [DW-1:0]    ram [DEPTH];
    logic [7:0]       sw_meta;
    logic [7:0]       sw_sync;

    logic             is_read;
    logic             is_write;
    logic             is_rsvd;
    logic             ram_hit;
    logic [IDX_W-1:0] ram_idx;
    logic             led_hit;
    logic             rd_bad;
    logic             wr_bad;
    logic             illegal;
    logic [DW-1:0]    read_data;

`ifdef ACCESS_COUNT_EN
    localparam logic [AW-1:0] CNT_ADDR1 = CNT_ADDR + 1'b1;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        cnt_clr;
`endif

    assign is_read  = (mem_cmd == CMD_READ);
    assign is_write = (mem_cmd == CMD_WRITE);
    assign is_rsvd  = (mem_cmd == CMD_RSVD);
    assign ram_hit  = ({1'b0, mem_addr} < DEPTH_A);
    assign ram_idx  = mem_addr[IDX_W-1:0];

    // Address decode. rd_bad / wr_bad mark which direction is illegal at the
    // addressed location; they only matter when qualified by the command.
    always_comb begin
        read_data = '0;
        led_hit   = 1'b0;
        rd_bad    = 1'b0;
        wr_bad    = 1'b0;
`ifdef ACCESS_COUNT_EN
        cnt_clr   = 1'b0;
`endif
        if (ram_hit) begin
            read_data = ram[ram_idx];
        end else if (mem_addr == LED_ADDR) begin
            led_hit = 1'b1;
            rd_bad  = 1'b1;
        end else if (mem_addr == SW_ADDR) begin
            read_data = {{(DW-8){1'b0}}, sw_sync};
            wr_bad    = 1'b1;
        end
`ifdef ACCESS_COUNT_EN
        else if (mem_addr == CNT_ADDR) begin
            read_data = DW'(rd_cnt);
            cnt_clr   = is_write;
        end else if (mem_addr == CNT_ADDR1) begin
            read_data = DW'(wr_cnt);
            wr_bad    = 1'b1;
        end
`endif
        else begin
            rd_bad = 1'b1;
            wr_bad = 1'b1;
        end
    end

    assign illegal = is_rsvd | (is_read & rd_bad) | (is_write & wr_bad);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
            ledr     <= 8'h00;
            err      <= 1'b0;
            sw_meta  <= 8'h00;
            sw_sync  <= 8'h00;
        end else begin
            rd_valid <= is_read;
            if (is_read) begin
                rdata <= read_data;
            end
            if (is_write && led_hit) begin
                ledr <= wdata[7:0];
            end
            if (illegal) begin
                err <= 1'b1;
            end
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (is_write && ram_hit) begin
            ram[ram_idx] <= wdata;
        end
    end

`ifdef ACCESS_COUNT_EN
    // Only RAM accesses are counted; a clear wins over any same-cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else if (cnt_clr) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (is_read && ram_hit && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (is_write && ram_hit && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder

module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LED_A = 256;
    localparam int SW_A  = 320;
    localparam int CNT_A = 384;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rd_valid;
    logic [7:0]  sw;
    logic [7:0]  ledr;
    logic        err;

    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .sw       (sw),
        .ledr     (ledr),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Behavioural model state: expected outputs after the most recent edge.
    logic [15:0] mram [DEPTH];
    bit          mwr  [DEPTH];
    logic [15:0] exp_rdata;
    bit          exp_known;
    bit          exp_valid;
    logic [7:0]  exp_led;
    bit          exp_err;
    logic [7:0]  sw_hist0;
    logic [7:0]  sw_hist1;
    int          m_rc;
    int          m_wc;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Compare process: every cycle outside reset, outputs must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (checking && !reset) begin
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
                if (exp_known) chk("rdata", {16'd0, rdata}, {16'd0, exp_rdata});
                chk("ledr", {24'd0, ledr}, {24'd0, exp_led});
                chk("err", {31'd0, err}, {31'd0, exp_err});
            end
        end
    end

    // Called at a falling edge: drives one bus command, advances the model over
    // the coming rising edge, and returns at the next falling edge.
    task automatic step(input logic [1:0] c, input int a, input int d);
        mem_cmd  = c;
        mem_addr = a[8:0];
        wdata    = d[15:0];
        exp_valid = (c == 2'b01);
        if (c == 2'b11) exp_err = 1'b1;
        if (c == 2'b01) begin
            exp_known = 1'b1;
            if (a < DEPTH) begin
                exp_rdata = mram[a];
                exp_known = mwr[a];
                if (m_rc < 65535) m_rc++;
            end else if (a == SW_A) begin
                exp_rdata = {8'h00, sw_hist1};
            end
`ifdef ACCESS_COUNT_EN
            else if (a == CNT_A)     exp_rdata = m_rc[15:0];
            else if (a == CNT_A + 1) exp_rdata = m_wc[15:0];
`endif
            else begin
                exp_rdata = 16'h0000;
                exp_err   = 1'b1;
            end
        end
        if (c == 2'b10) begin
            if (a < DEPTH) begin
                mram[a] = d[15:0];
                mwr[a]  = 1'b1;
                if (m_wc < 65535) m_wc++;
            end else if (a == LED_A) begin
                exp_led = d[7:0];
            end
`ifdef ACCESS_COUNT_EN
            else if (a == CNT_A) begin
                m_rc = 0;
                m_wc = 0;
            end
`endif
            else begin
                exp_err = 1'b1;
            end
        end
        sw_hist1 = sw_hist0;
        sw_hist0 = sw;
        @(negedge clk);
    endtask

    // Called at a falling edge: starts a READ, then asserts reset mid-cycle and
    // checks outputs clear before any further clock edge.
    task automatic do_reset();
        mem_cmd  = 2'b01;
        mem_addr = 9'h006;
        #1 reset = 1'b1;
        #1;
        chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset rdata", {16'd0, rdata}, 32'd0);
        chk("reset ledr", {24'd0, ledr}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        exp_rdata = 16'h0000;
        exp_known = 1'b1;
        exp_valid = 1'b0;
        exp_led   = 8'h00;
        exp_err   = 1'b0;
        sw_hist0  = 8'h00;
        sw_hist1  = 8'h00;
        m_rc      = 0;
        m_wc      = 0;
        mem_cmd   = 2'b00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        mem_cmd  = 2'b00;
        mem_addr = 9'h000;
        wdata    = 16'h0000;
        sw       = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            mram[i] = 16'h0000;
            mwr[i]  = 1'b0;
        end
        @(negedge clk);
        do_reset();
        checking = 1'b1;

        // Write then read-back, then idle: rdata holds.
        step(2'b10, 5, 16'hBEEF);
        step(2'b01, 5, 0);
        chk("lit beef rdata", {16'd0, rdata}, 32'h0000BEEF);
        chk("lit beef valid", {31'd0, rd_valid}, 32'd1);
        step(2'b00, 0, 0);
        chk("lit hold valid", {31'd0, rd_valid}, 32'd0);
        chk("lit hold rdata", {16'd0, rdata}, 32'h0000BEEF);

        // Back-to-back reads.
        step(2'b10, 0, 1);
        step(2'b10, 1, 2);
        step(2'b10, 2, 3);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, i, 0);
            chk("lit b2b rdata", {16'd0, rdata}, i + 1);
            chk("lit b2b valid", {31'd0, rd_valid}, 32'd1);
        end

        // LED register and synchronised switch port.
        step(2'b10, LED_A, 16'h12A5);
        chk("lit ledr", {24'd0, ledr}, 32'h000000A5);
        sw = 8'h3C;
        step(2'b00, 0, 0);
        step(2'b00, 0, 0);
        step(2'b01, SW_A, 0);
        chk("lit sw rdata", {16'd0, rdata}, 32'h0000003C);
        chk("lit sw err", {31'd0, err}, 32'd0);

`ifdef ACCESS_COUNT_EN
        step(2'b10, CNT_A, 0);
        step(2'b01, 0, 0);
        step(2'b01, 1, 0);
        step(2'b01, 2, 0);
        step(2'b10, 10, 16'h00AA);
        step(2'b10, 11, 16'h00BB);
        step(2'b01, CNT_A, 0);
        chk("lit rd_cnt", {16'd0, rdata}, 32'd3);
        step(2'b01, CNT_A + 1, 0);
        chk("lit wr_cnt", {16'd0, rdata}, 32'd2);
        step(2'b10, CNT_A, 0);
        step(2'b01, CNT_A, 0);
        chk("lit rd_cnt clr", {16'd0, rdata}, 32'd0);
        step(2'b01, CNT_A + 1, 0);
        chk("lit wr_cnt clr", {16'd0, rdata}, 32'd0);
        chk("lit cnt err", {31'd0, err}, 32'd0);
        step(2'b10, CNT_A + 1, 16'h1234);
        chk("lit cnt1 write err", {31'd0, err}, 32'd1);
`else
        step(2'b01, CNT_A, 0);
        chk("lit cnt unmapped err", {31'd0, err}, 32'd1);
        chk("lit cnt unmapped rdata", {16'd0, rdata}, 32'd0);
        chk("lit cnt unmapped valid", {31'd0, rd_valid}, 32'd1);
`endif

        // Unmapped read, sticky error, reserved command.
        do_reset();
        step(2'b01, 9'h1FF, 0);
        chk("lit unmapped rdata", {16'd0, rdata}, 32'd0);
        chk("lit unmapped valid", {31'd0, rd_valid}, 32'd1);
        chk("lit unmapped err", {31'd0, err}, 32'd1);
        step(2'b10, 7, 16'h7777);
        chk("lit err sticky", {31'd0, err}, 32'd1);
        do_reset();
        step(2'b11, 3, 0);
        chk("lit rsvd err", {31'd0, err}, 32'd1);
        chk("lit rsvd valid", {31'd0, rd_valid}, 32'd0);

        // Mixed directed vectors; the compare process checks every cycle.
        for (int i = 0; i < 12; i++) begin
            step(2'b10, (i * 37) % 256, (i * 16'h1357) ^ 16'h00A0);
        end
        for (int i = 0; i < 12; i++) begin
            sw = 8'((i * 7) + 1);
            step(2'b01, (i * 37) % 256, 0);
            if (i % 4 == 0) step(2'b01, SW_A, 0);
        end
        step(2'b10, SW_A, 16'h5555);
        step(2'b01, LED_A, 0);
        step(2'b10, LED_A, 16'h00FF);

        // Reset during a read; RAM survives reset.
        step(2'b01, 5, 0);
        do_reset();
        step(2'b01, 5, 0);
        chk("lit ram survives reset", {16'd0, rdata}, 32'h0000BEEF);
        step(2'b00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
